// File: rtl/qrd_boundary_cell_lambda.sv
`default_nettype none
// ============================================================================
// Module      : qrd_boundary_cell_lambda
// Description : QRD-RLS boundary cell with a forgetting factor. It holds the
//               diagonal element r. For each accepted sample x it computes
//               r' = sqrt((lambda*r)^2 + x^2), c = lambda*r/r' and s = x/r'.
//               A bit-serial square root and two lockstep restoring dividers
//               do the arithmetic, so latency is constant.
// Revision    : 1.0 - initial release
// ============================================================================
module qrd_boundary_cell_lambda #(
  parameter int W      = 16,
  parameter int FRAC   = 12,
  parameter int LAMBDA = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic         clear_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c_out,
  output logic [W-1:0] s_out,
  output logic [W-1:0] r_out,
  output logic         sat
);

  localparam int QW = FRAC + 2;           // quotient bits produced by DIV
  localparam int DW = W + FRAC + 1;       // divider partial-remainder width
  localparam int CW = $clog2(W + 1);      // iteration counter width
  localparam logic [W-1:0]  C_ONE  = W'(2 ** FRAC);
  localparam logic [QW-1:0] C_QONE = QW'(2 ** FRAC);
  localparam logic [W-1:0]  C_RMAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SQUARE = 3'd1,
    S_SQRT   = 3'd2,
    S_DIV    = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d, r_q, r_d, a_q, a_d, ax_q, ax_d;
  logic            clr_q, clr_d, satp_q, satp_d;
  logic [2*W-1:0]  sum_q, sum_d;
  logic [W:0]      rem_q, rem_d;
  logic [W-1:0]    root_q, root_d, rn_q, rn_d;
  logic [DW-1:0]   cr_q, cr_d, sr_q, sr_d, dvs_q, dvs_d;
  logic [QW-2:0]   qc_q, qc_d, qs_q, qs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    c_q, c_d, s_q, s_d, ro_q, ro_d;
  logic            sat_q, sat_d;

  // Squaring stage: lambda*r_eff and |x|, where |-2^(W-1)| = 2^(W-1) as unsigned
  logic [W-1:0]    w_r_eff, w_a, w_ax;
  logic [2*W-1:0]  w_sum;
  assign w_r_eff = clr_q ? '0 : r_q;
  assign w_a     = W'(({{W{1'b0}}, W'(LAMBDA)} * {{W{1'b0}}, w_r_eff}) >> FRAC);
  assign w_ax    = x_q[W-1] ? (~x_q + W'(1)) : x_q;
  assign w_sum   = {{W{1'b0}}, w_a} * {{W{1'b0}}, w_a}
                 + {{W{1'b0}}, w_ax} * {{W{1'b0}}, w_ax};

  // One restoring square-root step: bring down two radicand bits, try root*4+1
  logic [W+2:0]    w_rem_sh, w_trial;
  logic            w_rt_ge;
  logic [W:0]      w_rem_nx;
  logic [W-1:0]    w_root_nx, w_rn;
  assign w_rem_sh  = {rem_q, sum_q[2*W-1 -: 2]};
  assign w_trial   = {1'b0, root_q, 2'b01};
  assign w_rt_ge   = (w_rem_sh >= w_trial);
  assign w_rem_nx  = w_rt_ge ? (W+1)'(w_rem_sh - w_trial) : w_rem_sh[W:0];
  assign w_root_nx = {root_q[W-2:0], w_rt_ge};
  assign w_rn      = w_root_nx[W-1] ? C_RMAX : w_root_nx;

  // One restoring division step for each divider; the divisor shifts right.
  // Both numerators are at most rn+1, so QW quotient bits never overflow.
  logic            w_c_ge, w_s_ge;
  logic [DW-1:0]   w_cr_nx, w_sr_nx;
  logic [QW-1:0]   w_qc_nx, w_qs_nx, w_qc_cl, w_qs_cl;
  logic [W-1:0]    w_c_fin, w_s_mag, w_s_fin;
  assign w_c_ge  = (cr_q >= dvs_q);
  assign w_s_ge  = (sr_q >= dvs_q);
  assign w_cr_nx = w_c_ge ? (cr_q - dvs_q) : cr_q;
  assign w_sr_nx = w_s_ge ? (sr_q - dvs_q) : sr_q;
  assign w_qc_nx = {qc_q, w_c_ge};
  assign w_qs_nx = {qs_q, w_s_ge};
  assign w_qc_cl = (w_qc_nx > C_QONE) ? C_QONE : w_qc_nx;
  assign w_qs_cl = (w_qs_nx > C_QONE) ? C_QONE : w_qs_nx;
  // A zero root means a zero vector: rotate by identity (c=1, s=0)
  assign w_c_fin = (rn_q == '0) ? C_ONE : W'(w_qc_cl);
  assign w_s_mag = (rn_q == '0) ? '0 : W'(w_qs_cl);
  assign w_s_fin = x_q[W-1] ? (-w_s_mag) : w_s_mag;

  // Next-state and datapath update; every register holds unless its stage acts
  always_comb begin
    state_d = state_q;
    x_d = x_q; clr_d = clr_q; r_d = r_q; a_d = a_q; ax_d = ax_q;
    sum_d = sum_q; rem_d = rem_q; root_d = root_q; rn_d = rn_q; satp_d = satp_q;
    cr_d = cr_q; sr_d = sr_q; dvs_d = dvs_q; qc_d = qc_q; qs_d = qs_q;
    cnt_d = cnt_q;
    c_d = c_q; s_d = s_q; ro_d = ro_q; sat_d = sat_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          clr_d   = clear_in;
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        a_d     = w_a;
        ax_d    = w_ax;
        sum_d   = w_sum;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = S_SQRT;
      end
      S_SQRT: begin
        sum_d  = sum_q << 2;
        rem_d  = w_rem_nx;
        root_d = w_root_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          rn_d    = w_rn;
          satp_d  = w_root_nx[W-1];
          cr_d    = {1'b0, a_q,  {FRAC{1'b0}}};
          sr_d    = {1'b0, ax_q, {FRAC{1'b0}}};
          dvs_d   = {w_rn, {(FRAC+1){1'b0}}};
          qc_d    = '0;
          qs_d    = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        cr_d  = w_cr_nx;
        sr_d  = w_sr_nx;
        qc_d  = w_qc_nx[QW-2:0];
        qs_d  = w_qs_nx[QW-2:0];
        dvs_d = dvs_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(FRAC + 1)) begin
          c_d     = w_c_fin;
          s_d     = w_s_fin;
          ro_d    = rn_q;
          sat_d   = satp_q;
          r_d     = rn_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q <= '0; clr_q <= 1'b0; r_q <= '0; a_q <= '0; ax_q <= '0;
      sum_q <= '0; rem_q <= '0; root_q <= '0; rn_q <= '0; satp_q <= 1'b0;
      cr_q <= '0; sr_q <= '0; dvs_q <= '0; qc_q <= '0; qs_q <= '0;
      cnt_q <= '0;
      c_q <= '0; s_q <= '0; ro_q <= '0; sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d; clr_q <= clr_d; r_q <= r_d; a_q <= a_d; ax_q <= ax_d;
      sum_q <= sum_d; rem_q <= rem_d; root_q <= root_d; rn_q <= rn_d; satp_q <= satp_d;
      cr_q <= cr_d; sr_q <= sr_d; dvs_q <= dvs_d; qc_q <= qc_d; qs_q <= qs_d;
      cnt_q <= cnt_d;
      c_q <= c_d; s_q <= s_d; ro_q <= ro_d; sat_q <= sat_d;
    end
  end

  assign c_out = c_q;
  assign s_out = s_q;
  assign r_out = ro_q;
  assign sat   = sat_q;

endmodule
`default_nettype wire
